// File: rtl/anc_pkg.sv
// anc_pkg: shared types and constants for the ANC sample feeder.
//   Channel codes, the 64-bit frame payload and the assembly FSM states.
package anc_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CH_W     = 2;

  // ADC channel codes; code 3 is reserved and always treated as out of order.
  localparam logic [CH_W-1:0] CH_X   = 2'd0;
  localparam logic [CH_W-1:0] CH_E   = 2'd1;
  localparam logic [CH_W-1:0] CH_A   = 2'd2;
  localparam logic [CH_W-1:0] CH_RSV = 2'd3;

  // One assembled frame: reference, error, desired samples plus step size.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] x;
    logic signed [SAMPLE_W-1:0] e;
    logic signed [SAMPLE_W-1:0] a;
    logic signed [SAMPLE_W-1:0] u;
  } anc_frame_t;

  localparam int unsigned FRAME_W = $bits(anc_frame_t);

  // Assembly FSM: which channel is expected next.
  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_E = 2'd1,
    WAIT_A = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/anc_frame_fifo.sv
// anc_frame_fifo: synchronous show-ahead FIFO of anc_frame_t.
//   clk, rst_n        : clock, async active-low reset (empties the FIFO)
//   push, push_data   : write one frame (ignored when full unless popping)
//   pop               : consume the head frame (ignored when empty)
//   head              : registered head frame; holds last value when empty
//   valid/empty/full  : registered occupancy flags
//   level             : registered occupancy, 0..DEPTH
module anc_frame_fifo
  import anc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  anc_frame_t               push_data,
  input  logic                     pop,
  output anc_frame_t               head,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  anc_frame_t        mem [DEPTH];
  logic [PW-1:0]     rd_q, wr_q;
  logic [PW-1:0]     rd_d, wr_d, cnt_d;
  logic              push_ok_c, pop_ok_c;
  anc_frame_t        head_q;
  logic              valid_q, empty_q, full_q;
  logic [PW-1:0]     level_q;

  // Qualified handshakes: a full FIFO still accepts a push alongside a pop.
  always_comb begin
    pop_ok_c  = pop && !empty_q;
    push_ok_c = push && (!full_q || pop_ok_c);
    rd_d      = rd_q + PW'(pop_ok_c);
    wr_d      = wr_q + PW'(push_ok_c);
    cnt_d     = wr_d - rd_d;
  end

  // Storage array; no reset needed, pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_q[AW-1:0]] <= push_data;
  end

  // Pointers and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      level_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      valid_q <= (cnt_d != '0);
      empty_q <= (cnt_d == '0);
      full_q  <= (wr_d[PW-1] != rd_d[PW-1]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      level_q <= cnt_d;
    end
  end

  // Show-ahead head register; bypass when the next head is being written now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (cnt_d != '0) begin
      if (push_ok_c && (rd_d == wr_q)) head_q <= push_data;
      else                             head_q <= mem[rd_d[AW-1:0]];
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign level = level_q;

endmodule

// File: rtl/anc_sample_feeder.sv
// anc_sample_feeder: assembles x/e/a ADC samples into frames tagged with the
// LMS step size, buffers them and presents them on a valid/ready handshake.
//   clk, rst_n                 : clock, async active-low reset
//   adc_valid/adc_ch/adc_data  : serial per-channel sample strobe
//   mu_load/mu_cfg             : step-size register load
//   controller_ready           : downstream accepts the head frame
//   in_valid, x_in..u_in       : head frame (show-ahead)
//   sync_err                   : one-cycle pulse on channel-order violation
//   drop_cnt                   : saturating count of frames lost to a full FIFO
//   level                      : FIFO occupancy
module anc_sample_feeder
  import anc_pkg::*;
#(
  parameter int unsigned                DEPTH      = 4,
  parameter logic signed [SAMPLE_W-1:0] MU_DEFAULT = 16'sh0100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        adc_valid,
  input  logic [CH_W-1:0]             adc_ch,
  input  logic signed [SAMPLE_W-1:0]  adc_data,
  input  logic                        mu_load,
  input  logic signed [SAMPLE_W-1:0]  mu_cfg,
  input  logic                        controller_ready,
  output logic                        in_valid,
  output logic signed [SAMPLE_W-1:0]  x_in,
  output logic signed [SAMPLE_W-1:0]  e_in,
  output logic signed [SAMPLE_W-1:0]  a_in,
  output logic signed [SAMPLE_W-1:0]  u_in,
  output logic                        sync_err,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int unsigned DROP_W = 16;

  feeder_state_e              state_q, state_d;
  logic signed [SAMPLE_W-1:0] x_q, x_d;
  logic signed [SAMPLE_W-1:0] e_q, e_d;
  logic signed [SAMPLE_W-1:0] mu_q;
  logic                       sync_err_q, sync_err_d;
  logic [DROP_W-1:0]          drop_q;
  logic                       frame_done_c;
  logic                       pop_c, push_c, drop_c;
  anc_frame_t                 frame_c;
  anc_frame_t                 head;
  logic                       fifo_valid, fifo_empty, fifo_full;
  logic [$clog2(DEPTH):0]     fifo_level;

  // Assembly FSM state and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_X;
      x_q        <= '0;
      e_q        <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      e_q        <= e_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state: advance on the expected channel; an out-of-order x restarts
  // the frame from that sample, any other surprise restarts from WAIT_X.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    e_d          = e_q;
    sync_err_d   = 1'b0;
    frame_done_c = 1'b0;
    if (adc_valid) begin
      unique case (state_q)
        WAIT_X: begin
          if (adc_ch == CH_X) begin
            x_d     = adc_data;
            state_d = WAIT_E;
          end else begin
            sync_err_d = 1'b1;
            state_d    = WAIT_X;
          end
        end
        WAIT_E: begin
          if (adc_ch == CH_E) begin
            e_d     = adc_data;
            state_d = WAIT_A;
          end else if (adc_ch == CH_X) begin
            sync_err_d = 1'b1;
            x_d        = adc_data;
            state_d    = WAIT_E;
          end else begin
            sync_err_d = 1'b1;
            state_d    = WAIT_X;
          end
        end
        WAIT_A: begin
          if (adc_ch == CH_A) begin
            frame_done_c = 1'b1;
            state_d      = WAIT_X;
          end else if (adc_ch == CH_X) begin
            sync_err_d = 1'b1;
            x_d        = adc_data;
            state_d    = WAIT_E;
          end else begin
            sync_err_d = 1'b1;
            state_d    = WAIT_X;
          end
        end
        default: begin
          state_d = WAIT_X;
        end
      endcase
    end
  end

  // Frame payload carries the step size as it was before any same-cycle load.
  always_comb begin
    frame_c.x = x_q;
    frame_c.e = e_q;
    frame_c.a = adc_data;
    frame_c.u = mu_q;
  end

  // Handshake and drop decision; a pop frees the slot for a same-cycle push.
  always_comb begin
    pop_c  = fifo_valid && controller_ready;
    drop_c = frame_done_c && fifo_full && !pop_c;
    push_c = frame_done_c && !drop_c;
  end

  // Step-size register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mu_q <= MU_DEFAULT;
    else if (mu_load) mu_q <= mu_cfg;
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               drop_q <= '0;
    else if (drop_c && (drop_q != '1))        drop_q <= drop_q + DROP_W'(1);
  end

  anc_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_data (frame_c),
    .pop       (pop_c),
    .head      (head),
    .valid     (fifo_valid),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign in_valid = fifo_valid;
  assign x_in     = head.x;
  assign e_in     = head.e;
  assign a_in     = head.a;
  assign u_in     = head.u;
  assign sync_err = sync_err_q;
  assign drop_cnt = drop_q;
  assign level    = fifo_level;

  // fifo_empty mirrors fifo_valid; kept for visibility in waveforms.
  logic unused_c;
  assign unused_c = fifo_empty;

endmodule

// File: tb/tb_anc_sample_feeder.sv
// tb_anc_sample_feeder: directed stimulus, queue-based reference model checked
// every cycle, plus literal expectations taken from hand-worked scenarios.
module tb_anc_sample_feeder;

  localparam int unsigned DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               adc_valid;
  logic [1:0]         adc_ch;
  logic signed [15:0] adc_data;
  logic               mu_load;
  logic signed [15:0] mu_cfg;
  logic               controller_ready;
  logic               in_valid;
  logic signed [15:0] x_in, e_in, a_in, u_in;
  logic               sync_err;
  logic [15:0]        drop_cnt;
  logic [2:0]         level;

  anc_sample_feeder #(.DEPTH(DEPTH), .MU_DEFAULT(16'sh0100)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .adc_valid        (adc_valid),
    .adc_ch           (adc_ch),
    .adc_data         (adc_data),
    .mu_load          (mu_load),
    .mu_cfg           (mu_cfg),
    .controller_ready (controller_ready),
    .in_valid         (in_valid),
    .x_in             (x_in),
    .e_in             (e_in),
    .a_in             (a_in),
    .u_in             (u_in),
    .sync_err         (sync_err),
    .drop_cnt         (drop_cnt),
    .level            (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frames as {x,e,a,u}, queue for the buffer.
  logic [63:0] mq[$];
  logic [63:0] m_last;
  logic [15:0] m_mu, m_x, m_e, m_drop;
  int          m_got;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = '0; m_mu = 16'h0100; m_x = '0; m_e = '0;
      m_drop = '0; m_got = 0; m_err = 1'b0;
    end else begin
      logic        done, do_pop;
      logic [63:0] frm;
      done   = 1'b0;
      frm    = '0;
      m_err  = 1'b0;
      do_pop = (mq.size() != 0) && controller_ready;
      if (adc_valid) begin
        if (int'(adc_ch) == m_got) begin
          if (m_got == 0) m_x = adc_data;
          if (m_got == 1) m_e = adc_data;
          if (m_got == 2) begin done = 1'b1; frm = {m_x, m_e, adc_data, m_mu}; end
          m_got = (m_got + 1) % 3;
        end else begin
          m_err = 1'b1;
          if (adc_ch == 2'd0) begin m_x = adc_data; m_got = 1; end
          else m_got = 0;
        end
      end
      if (do_pop) m_last = mq.pop_front();
      if (done) begin
        if (mq.size() < DEPTH) mq.push_back(frm);
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (mu_load) m_mu = mu_cfg;
    end
  end

  // Compare process: DUT outputs against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [63:0] exp_head;
      exp_head = (mq.size() != 0) ? mq[0] : m_last;
      chk("m.in_valid", 64'(in_valid), 64'(mq.size() != 0));
      chk("m.level",    64'(level),    64'(mq.size()));
      chk("m.head",     {x_in, e_in, a_in, u_in}, exp_head);
      chk("m.sync_err", 64'(sync_err), 64'(m_err));
      chk("m.drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] ch, input logic [15:0] d);
    adc_valid = 1'b1; adc_ch = ch; adc_data = d;
    cyc();
    adc_valid = 1'b0;
  endtask

  task automatic triplet(input logic [15:0] x, input logic [15:0] e, input logic [15:0] a);
    strobe(2'd0, x); strobe(2'd1, e); strobe(2'd2, a);
  endtask

  initial begin
    rst_n = 1'b0; adc_valid = 1'b0; adc_ch = '0; adc_data = '0;
    mu_load = 1'b0; mu_cfg = '0; controller_ready = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst.in_valid", 64'(in_valid), 64'd0);
    chk("rst.level",    64'(level),    64'd0);
    chk("rst.x_in",     64'(x_in),     64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // In-order triplet, ready high: one-cycle in_valid with exact fields.
    controller_ready = 1'b1;
    triplet(16'h0123, 16'hFF00, 16'h7FFF);
    @(negedge clk);
    chk("t1.in_valid", 64'(in_valid), 64'd1);
    chk("t1.frame", {x_in, e_in, a_in, u_in}, 64'h0123_FF00_7FFF_0100);
    @(negedge clk);
    chk("t1.drained", 64'(in_valid), 64'd0);
    chk("t1.hold_x",  64'(x_in),     64'h0123);

    // Five frames with ready low: four buffered, one dropped, then drain.
    cyc();
    controller_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      triplet(16'(16'h1000 + i), 16'(16'h2000 + i), 16'(16'h3000 + i));
    @(negedge clk);
    chk("t2.level", 64'(level),    64'd4);
    chk("t2.drop",  64'(drop_cnt), 64'd1);
    chk("t2.x0",    64'(x_in),     64'h1000);
    controller_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("t2.pop_x", 64'(x_in), 64'(16'h1000 + i));
    end
    @(negedge clk);
    chk("t2.empty", 64'(in_valid), 64'd0);

    // Full FIFO, frame completes on the same cycle as a pop: accepted.
    cyc();
    controller_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      triplet(16'(16'h4000 + i), 16'(16'h5000 + i), 16'(16'h6000 + i));
    strobe(2'd0, 16'h4444);
    strobe(2'd1, 16'h5555);
    controller_ready = 1'b1;
    strobe(2'd2, 16'h6666);
    controller_ready = 1'b0;
    @(negedge clk);
    chk("t3.level", 64'(level),    64'd4);
    chk("t3.drop",  64'(drop_cnt), 64'd1);
    chk("t3.head",  64'(x_in),     64'h4001);
    cyc();
    controller_ready = 1'b1;
    repeat (5) cyc();
    @(negedge clk);
    chk("t3.last", {x_in, e_in, a_in, u_in}, 64'h4444_5555_6666_0100);

    // Out-of-order: x then a gives sync_err and no push; next triplet is good.
    cyc();
    strobe(2'd0, 16'h1111);
    strobe(2'd2, 16'h2222);
    @(negedge clk);
    chk("t4.sync_err", 64'(sync_err), 64'd1);
    chk("t4.no_push",  64'(in_valid), 64'd0);
    cyc();
    triplet(16'h3333, 16'h4444, 16'h5555);
    @(negedge clk);
    chk("t4.x", 64'(x_in), 64'h3333);
    cyc();
    strobe(2'd0, 16'h0001);
    strobe(2'd3, 16'h0002);
    strobe(2'd1, 16'h0003);
    strobe(2'd0, 16'h0004);
    strobe(2'd0, 16'h0005);
    strobe(2'd1, 16'h0006);
    strobe(2'd2, 16'h0007);
    @(negedge clk);
    chk("t4.restart", {x_in, e_in, a_in, u_in}, 64'h0005_0006_0007_0100);

    // Step-size load on the a-strobe: that frame keeps the old value.
    cyc();
    controller_ready = 1'b0;
    strobe(2'd0, 16'h0A01);
    strobe(2'd1, 16'h0B01);
    mu_load = 1'b1; mu_cfg = 16'sh0010;
    strobe(2'd2, 16'h0C01);
    mu_load = 1'b0;
    triplet(16'h0A02, 16'h0B02, 16'h0C02);
    @(negedge clk);
    chk("t5.level", 64'(level), 64'd2);
    chk("t5.u0",    64'(u_in),  64'h0100);
    controller_ready = 1'b1;
    @(negedge clk);
    chk("t5.u1",    64'(u_in),  64'h0010);
    cyc();

    // Reset with two frames queued and a frame half built.
    controller_ready = 1'b0;
    triplet(16'h7001, 16'h7002, 16'h7003);
    triplet(16'h7011, 16'h7012, 16'h7013);
    strobe(2'd0, 16'h7021);
    strobe(2'd1, 16'h7022);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6.in_valid", 64'(in_valid), 64'd0);
    chk("t6.level",    64'(level),    64'd0);
    cyc();
    strobe(2'd2, 16'h7023);
    @(negedge clk);
    chk("t6.stray_a", 64'(in_valid), 64'd0);
    controller_ready = 1'b1;
    cyc();
    triplet(16'h0AAA, 16'h0BBB, 16'h0CCC);
    @(negedge clk);
    chk("t6.frame", {x_in, e_in, a_in, u_in}, 64'h0AAA_0BBB_0CCC_0100);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
